rng_roll_hold: RTL
==================

RNG_ROLL_HOLD -- requirements
Module: rng_roll_hold

Interface
REQ-001 SHALL have parameter TICK_DIV, default 5_000_000: CLK cycles per roll tick (10 Hz at 50 MHz); legal range >=2.
REQ-002 SHALL have parameter ROLL_TICKS, default 20: ticks per roll; legal range >=1.
REQ-003 SHALL have parameter DB_CYCLES, default 500_000: cycles BTN must be stable to be accepted; legal range >=1.
REQ-004 SHALL have port CLK  input  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port EN  input  1  reset, synchronous and active-low; acts only at a CLK rising edge.
REQ-006 SHALL have port rnd_in  input  8  random byte from the upstream PRNG mux stage.
REQ-007 SHALL have port rnd_valid  input  1  one-cycle strobe marking rnd_in as new.
REQ-008 SHALL have port BTN  input  1  raw, asynchronous, active-high push button.
REQ-009 SHALL have port held  output  8  displayed/frozen random value.
REQ-010 SHALL have port busy  output  1  high while in ROLL.
REQ-011 SHALL have port done  output  1  one-cycle pulse when a roll completes.
REQ-012 SHALL have port HEX0  output  7  active-low 7-seg (bit0=a..bit6=g) for held[3:0].
REQ-013 SHALL have port HEX1  output  7  active-low 7-seg for held[7:4].

Function
REQ-014 BTN SHALL pass through a 2-flop synchroniser, then a debouncer: btn_db takes the synchronised level only after DB_CYCLES consecutive cycles of that level differing from btn_db.
REQ-015 A press SHALL be a one-cycle pulse on a 0->1 transition of btn_db.
REQ-016 last_rnd SHALL capture rnd_in on every cycle with rnd_valid=1, in all states.
REQ-017 The FSM SHALL have states IDLE, ROLL and HOLD.
REQ-018 IDLE transitions: press -> ROLL; no other transition.
REQ-019 ROLL transitions: final tick -> HOLD; no other transition.
REQ-020 HOLD transitions: press -> ROLL; no other transition.
REQ-021 Entering ROLL SHALL clear the tick counter and roll_cnt to 0.
REQ-022 In ROLL, the tick counter SHALL count 0..TICK_DIV-1 and then wrap; tick SHALL be asserted in the cycle where the count equals TICK_DIV-1.
REQ-023 The tick counter SHALL be held at 0 outside ROLL.
REQ-024 On each tick, held SHALL load last_rnd and roll_cnt SHALL increment.
REQ-025 If rnd_valid=1 in the same cycle as a tick, held SHALL load rnd_in directly (bypass).
REQ-026 The tick with roll_cnt==ROLL_TICKS-1 SHALL perform the final load and move to HOLD; done SHALL be 1 in the following cycle only.
REQ-027 A press during ROLL SHALL be ignored; the roll length SHALL remain exactly ROLL_TICKS ticks.
REQ-028 busy SHALL equal (state==ROLL), registered.
REQ-029 HEX0 and HEX1 SHALL be registered and lag held by one cycle.
REQ-030 In IDLE, HEX0 and HEX1 SHALL show a dash (7'b0111111).
REQ-031 In ROLL and HOLD, HEX0 and HEX1 SHALL show standard hex glyphs: 0=1000000, 5=0010010, 8=0000000, A=0001000, F=0001110, and so on.
REQ-032 held SHALL change only in ROLL ticks and at reset.

Reset
REQ-033 With EN=0 at a CLK edge, the block SHALL set state=IDLE, held=8'h00, busy=0, done=0, HEX0=HEX1=7'b0111111, and clear all counters, synchroniser flops, btn_db and last_rnd.
REQ-034 EN=0 mid-ROLL SHALL abort to IDLE with no done pulse; EN=1 SHALL resume normal operation on the next edge.
REQ-035 No asynchronous reset path SHALL exist.

Verification (TICK_DIV=4, ROLL_TICKS=3, DB_CYCLES=2)
REQ-036 Reset: EN=0 for 2 cycles with random BTN/rnd -> held=00, busy=0, done=0, HEX0=HEX1=0111111.
REQ-037 Roll: rnd_valid=1 every cycle with an incrementing rnd_in, BTN held high -> busy rises; held updates 3 times at 4-cycle spacing; done pulses once, 1 cycle after the third load; state=HOLD; held equals the rnd_in of the final tick cycle; held=A5 gives HEX1=0001000, HEX0=0010010 one cycle later.
REQ-038 Bounce: BTN high for 1 cycle only -> no press, state unchanged, busy=0.
REQ-039 Press during ROLL: release and re-press BTN mid-roll -> still exactly 3 loads and 1 done; a new press in HOLD starts a fresh roll.
REQ-040 Abort: EN=0 after the first tick of a roll -> next edge IDLE, busy=0, held=00, dash display, no done.
REQ-041 Bypass: rnd_valid=1 with rnd_in=3C in a tick cycle -> held=3C next cycle, not the previous last_rnd.

Source files
------------

// File: rtl/rng_roll_hold.sv
// Button-triggered dice roller: debounced press starts a roll that samples the
// upstream random byte on ROLL_TICKS slow ticks, then freezes it on 7-seg.
module rng_roll_hold #(
  parameter int TICK_DIV   = 5_000_000,
  parameter int ROLL_TICKS = 20,
  parameter int DB_CYCLES  = 500_000
) (
  input  logic       CLK,
  input  logic       EN,
  input  logic [7:0] rnd_in,
  input  logic       rnd_valid,
  input  logic       BTN,
  output logic [7:0] held,
  output logic       busy,
  output logic       done,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1
);

  localparam int TICK_W = $clog2(TICK_DIV);
  localparam int ROLL_W = $clog2(ROLL_TICKS + 1);
  localparam int DB_W   = $clog2(DB_CYCLES + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ROLL = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  localparam logic [6:0] SEG_DASH = 7'b0111111;

  function automatic logic [6:0] hex_glyph(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'h0:    g = 7'b1000000;
      4'h1:    g = 7'b1111001;
      4'h2:    g = 7'b0100100;
      4'h3:    g = 7'b0110000;
      4'h4:    g = 7'b0011001;
      4'h5:    g = 7'b0010010;
      4'h6:    g = 7'b0000010;
      4'h7:    g = 7'b1111000;
      4'h8:    g = 7'b0000000;
      4'h9:    g = 7'b0010000;
      4'hA:    g = 7'b0001000;
      4'hB:    g = 7'b0000011;
      4'hC:    g = 7'b1000110;
      4'hD:    g = 7'b0100001;
      4'hE:    g = 7'b0000110;
      default: g = 7'b0001110;
    endcase
    return g;
  endfunction

  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;
  logic              db_q, db_d;
  logic              db_prev_q, db_prev_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic [7:0]        last_q, last_d;
  logic [1:0]        state_q, state_d;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [ROLL_W-1:0] roll_cnt_q, roll_cnt_d;
  logic [7:0]        held_q, held_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [6:0]        hex0_q, hex0_d;
  logic [6:0]        hex1_q, hex1_d;

  logic press;
  logic tick;
  logic final_tick;

  assign press      = db_q & ~db_prev_q;
  assign tick       = (state_q == S_ROLL) && (tick_cnt_q == TICK_W'(TICK_DIV - 1));
  assign final_tick = tick && (roll_cnt_q == ROLL_W'(ROLL_TICKS - 1));

  // Synchroniser and debouncer: counter tracks consecutive cycles of disagreement.
  always_comb begin
    sync1_d   = BTN;
    sync2_d   = sync1_q;
    db_d      = db_q;
    db_cnt_d  = '0;
    db_prev_d = db_q;
    if (sync2_q != db_q) begin
      if (db_cnt_q == DB_W'(DB_CYCLES - 1)) begin
        db_d     = sync2_q;
        db_cnt_d = '0;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    last_d     = rnd_valid ? rnd_in : last_q;
    state_d    = state_q;
    tick_cnt_d = '0;
    roll_cnt_d = roll_cnt_q;
    held_d     = held_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE, S_HOLD: begin
        if (press) begin
          state_d    = S_ROLL;
          roll_cnt_d = '0;
        end
      end
      S_ROLL: begin
        if (tick) begin
          // Same-cycle strobe wins over the captured byte.
          held_d     = rnd_valid ? rnd_in : last_q;
          roll_cnt_d = roll_cnt_q + 1'b1;
          if (final_tick) begin
            state_d = S_HOLD;
            done_d  = 1'b1;
          end
        end else begin
          tick_cnt_d = tick_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_ROLL);
    hex0_d = (state_q == S_IDLE) ? SEG_DASH : hex_glyph(held_q[3:0]);
    hex1_d = (state_q == S_IDLE) ? SEG_DASH : hex_glyph(held_q[7:4]);
  end

  always_ff @(posedge CLK) begin
    if (!EN) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      db_q       <= 1'b0;
      db_prev_q  <= 1'b0;
      db_cnt_q   <= '0;
      last_q     <= '0;
      state_q    <= S_IDLE;
      tick_cnt_q <= '0;
      roll_cnt_q <= '0;
      held_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      hex0_q     <= SEG_DASH;
      hex1_q     <= SEG_DASH;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      db_q       <= db_d;
      db_prev_q  <= db_prev_d;
      db_cnt_q   <= db_cnt_d;
      last_q     <= last_d;
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      roll_cnt_q <= roll_cnt_d;
      held_q     <= held_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      hex0_q     <= hex0_d;
      hex1_q     <= hex1_d;
    end
  end

  assign held = held_q;
  assign busy = busy_q;
  assign done = done_q;
  assign HEX0 = hex0_q;
  assign HEX1 = hex1_q;

endmodule
